stable_matching_seq: RTL and testbench
======================================

Name: stable_matching_seq

Overview:
Sequential, clocked Gale-Shapley engine. It replaces the fully unrolled combinational stable-matching chain with one proposal evaluated per clock cycle, so area is independent of iteration count. It latches both preference lists on start, iterates until no free proposer can propose, then presents the matching in the same packed output format as the combinational block. Added over the combinational block: start/busy/done handshake, a per-receiver matched flag, and a proposal counter.

Parameters:
S, 10, members of proposing list A
R, S, members of receiving list B
Ks, R, preference-list length per A member
Kr, S, preference-list length per B member
(derived, not overridable: logS=log2(S), logR=log2(R), PCW=log2(Ks+1), CNTW=log2(S*Ks+1))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a run; sampled only in IDLE or DONE
p_input  in  R*Kr*logS+S*Ks*logR  preferences; rPref in low R*Kr*logS bits, sPref above; entry j of member i at [w*K*i+w*j +: w]
busy  out  1  high while running
done  out  1  high from run completion until next start
o  out  R*logS+1  {finish, matchList}; matchList field i = A partner of B member i
r_matched  out  R  B member i currently holds a partner
proposals  out  CNTW  proposals evaluated this run

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: FSM=IDLE. busy=0, done=0, o=0, r_matched=0, proposals=0. All pc=0, sIsMatch=0, preference registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 (next cycle):
  - latch p_input;
  - all pc<=Ks, sIsMatch<=0, r_matched<=0, matchList<=0, proposals<=0;
  - done<=0, busy<=1, go to RUN.
- start in RUN is ignored. p_input changes after the start cycle have no effect.
- RUN, each cycle:
  - canPropose[i] = (pc[i]!=0) & ~sIsMatch[i].
  - s = lowest index with canPropose set.
  - If none: go to DONE, busy<=0, done<=1, o[R*logS]<=1.
  - Otherwise:
    - r = sPref[s][Ks-pc[s]];
    - pc[s]--; proposals++;
    - if ~r_matched[r]: match r to s, set r_matched[r] and sIsMatch[s];
    - else if s ranks strictly earlier than current partner s1 in rPref[r] (first-occurrence rule; s absent from the list counts as worse): r takes s, sIsMatch[s1]<=0, sIsMatch[s]<=1;
    - else no match change.
- Latency: proposals+1 cycles from the first RUN cycle to done. Worst case S*Ks+1.
- o matchList bits update in the same cycle as the match; finish bit is 0 until DONE.
- Duplicate entries in one A list are legal; each is a separate proposal.
- Asynchronous reset mid-run aborts immediately and returns all outputs to reset values.
- The counter cannot wrap: CNTW is sized for S*Ks.

Optional Feature:
STABLE_MATCHING_ITER_LIMIT_EN
- Defined: adds parameter MAX_ITER (default S*Ks) and output aborted (1 bit, reset 0, cleared on start). When proposals reaches MAX_ITER in RUN, the FSM goes to DONE with aborted=1, done=1 and o[R*logS]=0; the partial matchList is held.
- Undefined: no port, no parameter; the run always terminates by exhaustion.

Decomposition:
- Shared include stable_matching_defs.vh: log2 function, width localparam formulas, state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module stable_matching_rank_cmp (combinational): inputs r's Kr-entry list, s, s1; output better. Proposer selection reuses the existing encoder module with a one-hot priority mask.

Test Plan:
- Reset mid-run: assert rst at cycle 3 of a run -> busy=0, done=0, o=0, r_matched=0, proposals=0 the same cycle.
- S=R=Ks=Kr=2, sPref s0=[r0,r1], s1=[r0,r1], rPref r0=[s1,s0], r1=[s0,s1], start -> displacement occurs; done after 4 RUN cycles; matchList r0=1, r1=0; proposals=3; o=3'b101.
- S=R=4, identity preferences (s_i lists r_i first, r_i lists s_i first) -> 4 proposals; matchList[i]=i; done at RUN cycle 5.
- S=R=4, all A lists identical [r0..r3], rPref all [s3,s2,s1,s0] -> stable result r0=s3, r1=s2, r2=s1, r3=s0; r_matched=4'hF.
- Start pulsed during RUN and p_input toggled -> ignored; result identical to the undisturbed run. Second start from DONE reruns cleanly with proposals reset.
- With STABLE_MATCHING_ITER_LIMIT_EN, MAX_ITER=2 on the 2x2 case -> aborted=1, done=1, finish=0, proposals=2.

Source files
------------

// File: rtl/stable_matching_seq_pkg.sv
// Shared types and width helpers for the sequential stable-matching engine.
// The optional iteration limit is enabled by STABLE_MATCHING_ITER_LIMIT_EN.
package stable_matching_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stable_matching_rank_cmp.sv
// Decides whether proposer s ranks strictly ahead of current partner s1 in a
// receiver's preference list; only the first occurrence of a member counts.
module stable_matching_rank_cmp
    import stable_matching_seq_pkg::*;
#(
    parameter int Kr   = 10,
    parameter int LOG_S = 4
) (
    input  logic [Kr*LOG_S-1:0] pref_list,
    input  logic [LOG_S-1:0]    s,
    input  logic [LOG_S-1:0]    s1,
    output logic                better
);

    localparam int RKW = clog2_min1(Kr);

    logic [LOG_S-1:0] entry [Kr];
    logic             s_found;
    logic             s1_found;
    logic [RKW-1:0]   s_rank;
    logic [RKW-1:0]   s1_rank;

    for (genvar gi = 0; gi < Kr; gi++) begin : g_entry
        assign entry[gi] = pref_list[gi*LOG_S +: LOG_S];
    end

    // Scanning from the tail lets the earliest match overwrite later ones.
    always_comb begin
        s_found  = 1'b0;
        s1_found = 1'b0;
        s_rank   = '0;
        s1_rank  = '0;
        for (int j = Kr - 1; j >= 0; j--) begin
            if (entry[j] == s) begin
                s_found = 1'b1;
                s_rank  = RKW'(j);
            end
            if (entry[j] == s1) begin
                s1_found = 1'b1;
                s1_rank  = RKW'(j);
            end
        end
    end

    // A member missing from the list loses to any member that appears.
    assign better = s_found && (!s1_found || (s_rank < s1_rank));

endmodule

// File: rtl/stable_matching_seq.sv
// Gale-Shapley engine evaluating one proposal per clock; presents {finish, matchList}.
// Define STABLE_MATCHING_ITER_LIMIT_EN to add MAX_ITER and the aborted output.
module stable_matching_seq
    import stable_matching_seq_pkg::*;
#(
    parameter int S  = 10,
    parameter int R  = S,
    parameter int Ks = R,
    parameter int Kr = S,
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
    parameter int MAX_ITER = S * Ks,
`endif
    localparam int LOG_S = clog2_min1(S),
    localparam int LOG_R = clog2_min1(R),
    localparam int PCW   = clog2_min1(Ks + 1),
    localparam int CNTW  = clog2_min1(S * Ks + 1),
    localparam int RPW   = R * Kr * LOG_S,
    localparam int SPW   = S * Ks * LOG_R
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [RPW+SPW-1:0] p_input,
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
    output logic               aborted,
`endif
    output logic               busy,
    output logic               done,
    output logic [R*LOG_S:0]   o,
    output logic [R-1:0]       r_matched,
    output logic [CNTW-1:0]    proposals
);

    state_e           state_q, state_d;
    logic [RPW-1:0]   r_pref_q, r_pref_d;
    logic [SPW-1:0]   s_pref_q, s_pref_d;
    logic [PCW-1:0]   pc_q [S];
    logic [PCW-1:0]   pc_d [S];
    logic [S-1:0]     s_is_match_q, s_is_match_d;
    logic [R-1:0]     r_matched_q, r_matched_d;
    logic [LOG_S-1:0] match_q [R];
    logic [LOG_S-1:0] match_d [R];
    logic [CNTW-1:0]  proposals_q, proposals_d;
    logic             finish_q, finish_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
    logic             aborted_q, aborted_d;
`endif

    logic [S-1:0]          can_propose;
    logic [S-1:0]          lowest_oh;
    logic [Ks*LOG_R-1:0]   s_list [S];
    logic [Kr*LOG_S-1:0]   r_list [R];
    logic                  found;
    logic [LOG_S-1:0]      s_sel;
    logic [PCW-1:0]        pc_sel;
    logic [Ks*LOG_R-1:0]   s_list_sel;
    logic [LOG_R-1:0]      r_sel;
    logic                  r_valid;
    logic [LOG_S-1:0]      holder;
    logic [Kr*LOG_S-1:0]   r_list_sel;
    logic                  better;
    int                    pref_idx;

    for (genvar gi = 0; gi < S; gi++) begin : g_prop
        assign can_propose[gi] = (pc_q[gi] != '0) && !s_is_match_q[gi];
        assign s_list[gi]      = s_pref_q[gi*Ks*LOG_R +: Ks*LOG_R];
    end

    for (genvar gi = 0; gi < R; gi++) begin : g_recv
        assign r_list[gi]              = r_pref_q[gi*Kr*LOG_S +: Kr*LOG_S];
        assign o[gi*LOG_S +: LOG_S]    = match_q[gi];
    end
    assign o[R*LOG_S] = finish_q;

    // Isolate the lowest free proposer as a one-hot mask, then encode it.
    assign lowest_oh = can_propose & (~can_propose + S'(1));
    assign found     = |can_propose;

    always_comb begin
        s_sel = '0;
        for (int i = 0; i < S; i++) begin
            if (lowest_oh[i]) begin
                s_sel = s_sel | LOG_S'(i);
            end
        end
    end

    // Next receiver in s's list; pc counts down so entry Ks-pc is next.
    always_comb begin
        pc_sel     = pc_q[s_sel];
        pref_idx   = (pc_sel == '0) ? 0 : (Ks - int'(pc_sel));
        s_list_sel = s_list[s_sel];
        r_sel      = s_list_sel[pref_idx*LOG_R +: LOG_R];
        r_valid    = int'(r_sel) < R;
        holder     = r_valid ? match_q[r_sel] : '0;
        r_list_sel = r_valid ? r_list[r_sel] : '0;
    end

    stable_matching_rank_cmp #(
        .Kr    (Kr),
        .LOG_S (LOG_S)
    ) u_rank_cmp (
        .pref_list (r_list_sel),
        .s         (s_sel),
        .s1        (holder),
        .better    (better)
    );

    always_comb begin
        state_d      = state_q;
        r_pref_d     = r_pref_q;
        s_pref_d     = s_pref_q;
        pc_d         = pc_q;
        s_is_match_d = s_is_match_q;
        r_matched_d  = r_matched_q;
        match_d      = match_q;
        proposals_d  = proposals_q;
        finish_d     = finish_q;
        busy_d       = busy_q;
        done_d       = done_q;
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
        aborted_d    = aborted_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    r_pref_d     = p_input[RPW-1:0];
                    s_pref_d     = p_input[RPW+SPW-1:RPW];
                    for (int i = 0; i < S; i++) pc_d[i] = PCW'(Ks);
                    for (int i = 0; i < R; i++) match_d[i] = '0;
                    s_is_match_d = '0;
                    r_matched_d  = '0;
                    proposals_d  = '0;
                    finish_d     = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
                    aborted_d    = 1'b0;
`endif
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!found) begin
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    finish_d = 1'b1;
                end
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
                else if (int'(proposals_q) >= MAX_ITER) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
`endif
                else begin
                    pc_d[s_sel] = pc_sel - PCW'(1);
                    proposals_d = proposals_q + CNTW'(1);
                    if (r_valid) begin
                        if (!r_matched_q[r_sel]) begin
                            match_d[r_sel]      = s_sel;
                            r_matched_d[r_sel]  = 1'b1;
                            s_is_match_d[s_sel] = 1'b1;
                        end else if (better) begin
                            match_d[r_sel]       = s_sel;
                            s_is_match_d[holder] = 1'b0;
                            s_is_match_d[s_sel]  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            r_pref_q     <= '0;
            s_pref_q     <= '0;
            for (int i = 0; i < S; i++) pc_q[i] <= '0;
            for (int i = 0; i < R; i++) match_q[i] <= '0;
            s_is_match_q <= '0;
            r_matched_q  <= '0;
            proposals_q  <= '0;
            finish_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            r_pref_q     <= r_pref_d;
            s_pref_q     <= s_pref_d;
            pc_q         <= pc_d;
            match_q      <= match_d;
            s_is_match_q <= s_is_match_d;
            r_matched_q  <= r_matched_d;
            proposals_q  <= proposals_d;
            finish_q     <= finish_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
            aborted_q    <= aborted_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign r_matched = r_matched_q;
    assign proposals = proposals_q;
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_stable_matching_seq.sv
// Bench for stable_matching_seq: a 4x4 instance driven from a vector table with a
// scoreboard queue, and a 2x2 instance for the displacement / iteration-limit case.
module tb_stable_matching_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start4;
    logic [63:0] p4;
    logic        busy4, done4;
    logic [8:0]  o4;
    logic [3:0]  rm4;
    logic [4:0]  prop4;

    logic        start2;
    logic [7:0]  p2;
    logic        busy2, done2;
    logic [2:0]  o2;
    logic [1:0]  rm2;
    logic [2:0]  prop2;

`ifdef STABLE_MATCHING_ITER_LIMIT_EN
    logic ab4, ab2;

    stable_matching_seq #(.S(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .p_input(p4), .aborted(ab4),
        .busy(busy4), .done(done4), .o(o4), .r_matched(rm4), .proposals(prop4)
    );

    stable_matching_seq #(.S(2), .MAX_ITER(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .p_input(p2), .aborted(ab2),
        .busy(busy2), .done(done2), .o(o2), .r_matched(rm2), .proposals(prop2)
    );
`else
    stable_matching_seq #(.S(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .p_input(p4),
        .busy(busy4), .done(done4), .o(o4), .r_matched(rm4), .proposals(prop4)
    );

    stable_matching_seq #(.S(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .p_input(p2),
        .busy(busy2), .done(done2), .o(o2), .r_matched(rm2), .proposals(prop2)
    );
`endif

    typedef struct {
        logic [31:0] s_pref;
        logic [31:0] r_pref;
        logic [7:0]  exp_match;
        logic [4:0]  exp_prop;
        logic [3:0]  exp_rm;
    } vec_t;

    typedef struct {
        int          id;
        logic [7:0]  exp_match;
        logic [4:0]  exp_prop;
        logic [3:0]  exp_rm;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [7:0] lst(input int a, input int b, input int c, input int d);
        logic [1:0] ea, eb, ec, ed;
        ea = 2'(a); eb = 2'(b); ec = 2'(c); ed = 2'(d);
        return {ed, ec, eb, ea};
    endfunction

    function automatic logic [31:0] pk(input logic [7:0] l0, input logic [7:0] l1,
                                       input logic [7:0] l2, input logic [7:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mode 0: plain run, 1: start pulse and p_input change mid-run, 2: reset at RUN cycle 3
    task automatic run4(input int vi, input int mode);
        exp_t e;
        int   cyc;
        bit   got;
        @(negedge clk);
        p4     = {vecs[vi].s_pref, vecs[vi].r_pref};
        start4 = 1'b1;
        if (mode != 2) begin
            e.id        = vi;
            e.exp_match = vecs[vi].exp_match;
            e.exp_prop  = vecs[vi].exp_prop;
            e.exp_rm    = vecs[vi].exp_rm;
            sb.push_back(e);
        end
        @(negedge clk);
        start4 = 1'b0;
        check("busy_after_start", 32'(busy4), 32'd1);
        check("done_after_start", 32'(done4), 32'd0);
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done4) got = 1;
            if (mode == 1 && cyc == 2) begin
                start4 = 1'b1;
                p4     = ~p4;
            end
            if (mode == 1 && cyc == 3) start4 = 1'b0;
            if (mode == 2 && cyc == 3) begin
                rst = 1'b1;
                #1;
                check("rst_busy", 32'(busy4), 32'd0);
                check("rst_done", 32'(done4), 32'd0);
                check("rst_o", 32'(o4), 32'd0);
                check("rst_r_matched", 32'(rm4), 32'd0);
                check("rst_proposals", 32'(prop4), 32'd0);
                $display("[TB] vec %0d aborted by reset at RUN cycle 3", vi);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        if (sb.size() > 0) e = sb.pop_front();
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: vec %0d got no done in %0d cycles, expected %0d", vi, cyc, e.exp_prop + 1);
        end else begin
            check("run_cycles", 32'(cyc), 32'(e.exp_prop) + 32'd1);
            check("match_list", 32'(o4[7:0]), 32'(e.exp_match));
            check("finish", 32'(o4[8]), 32'd1);
            check("r_matched", 32'(rm4), 32'(e.exp_rm));
            check("proposals", 32'(prop4), 32'(e.exp_prop));
            check("busy_at_done", 32'(busy4), 32'd0);
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
            check("aborted4", 32'(ab4), 32'd0);
`endif
            $display("[TB] vec %0d mode %0d: match=%h r_matched=%h proposals=%0d cycles=%0d",
                     e.id, mode, o4[7:0], rm4, prop4, cyc);
        end
    endtask

    initial begin
        int  cyc;
        bit  got;
        logic [8:0] held;

        // identity preferences
        vecs[0].s_pref    = pk(lst(0,1,2,3), lst(1,2,3,0), lst(2,3,0,1), lst(3,0,1,2));
        vecs[0].r_pref    = pk(lst(0,1,2,3), lst(1,2,3,0), lst(2,3,0,1), lst(3,0,1,2));
        vecs[0].exp_match = 8'hE4; vecs[0].exp_prop = 5'd4;  vecs[0].exp_rm = 4'hF;
        // identical A lists, reversed B lists
        vecs[1].s_pref    = pk(lst(0,1,2,3), lst(0,1,2,3), lst(0,1,2,3), lst(0,1,2,3));
        vecs[1].r_pref    = pk(lst(3,2,1,0), lst(3,2,1,0), lst(3,2,1,0), lst(3,2,1,0));
        vecs[1].exp_match = 8'h1B; vecs[1].exp_prop = 5'd10; vecs[1].exp_rm = 4'hF;
        // duplicate A entries, absent members, repeated s1 in r0's list
        vecs[2].s_pref    = 32'h0;
        vecs[2].r_pref    = pk(lst(1,2,1,1), lst(0,1,2,3), lst(0,1,2,3), lst(0,1,2,3));
        vecs[2].exp_match = 8'h01; vecs[2].exp_prop = 5'd13; vecs[2].exp_rm = 4'h1;
        // mixed preferences with one displacement
        vecs[3].s_pref    = pk(lst(1,0,2,3), lst(1,2,0,3), lst(0,1,2,3), lst(0,2,1,3));
        vecs[3].r_pref    = pk(lst(3,2,1,0), lst(0,1,2,3), lst(1,0,3,2), lst(0,1,2,3));
        vecs[3].exp_match = 8'h93; vecs[3].exp_prop = 5'd8;  vecs[3].exp_rm = 4'hF;

        rst    = 1'b0;
        start4 = 1'b0;
        start2 = 1'b0;
        p4     = '0;
        p2     = '0;
        #2 rst = 1'b1;
        #1;
        check("reset_busy", 32'(busy4), 32'd0);
        check("reset_done", 32'(done4), 32'd0);
        check("reset_o", 32'(o4), 32'd0);
        check("reset_r_matched", 32'(rm4), 32'd0);
        check("reset_proposals", 32'(prop4), 32'd0);
        check("reset_o2", 32'(o2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run4(i, 0);

        run4(1, 1);
        held = o4;
        repeat (3) @(negedge clk);
        check("done_held", 32'(done4), 32'd1);
        check("o_held", 32'(o4), 32'(held));

        run4(0, 0);
        run4(1, 2);
        run4(3, 0);

        // 2x2 displacement: s0=[r0,r1], s1=[r0,r1], r0=[s1,s0], r1=[s0,s1]
        @(negedge clk);
        p2     = 8'b1010_1001;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done2) got = 1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout_2x2: no done after %0d cycles", cyc);
        end else begin
`ifdef STABLE_MATCHING_ITER_LIMIT_EN
            check("abort_cycles", 32'(cyc), 32'd3);
            check("abort_o", 32'(o2), 32'b001);
            check("abort_proposals", 32'(prop2), 32'd2);
            check("abort_flag", 32'(ab2), 32'd1);
            check("abort_r_matched", 32'(rm2), 32'b01);
`else
            check("2x2_cycles", 32'(cyc), 32'd4);
            check("2x2_o", 32'(o2), 32'b101);
            check("2x2_proposals", 32'(prop2), 32'd3);
            check("2x2_r_matched", 32'(rm2), 32'b11);
`endif
            check("2x2_busy", 32'(busy2), 32'd0);
            $display("[TB] 2x2 run: o=%b r_matched=%b proposals=%0d cycles=%0d", o2, rm2, prop2, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
